// File: rtl/qei_pkg.sv
// Shared definitions for the quadrature encoder front end: step encoding,
// the {a,b} transition decoder and a range check used for saturation.
package qei_pkg;

    // Encoded step produced by one decoded {a,b} transition.
    typedef logic [1:0] step_t;

    localparam step_t STEP_NONE = 2'b00;
    localparam step_t STEP_UP   = 2'b01;
    localparam step_t STEP_DOWN = 2'b10;
    localparam step_t STEP_ERR  = 2'b11;

    // Result of a saturation range check.
    localparam logic [1:0] SAT_IN = 2'b00;
    localparam logic [1:0] SAT_HI = 2'b01;
    localparam logic [1:0] SAT_LO = 2'b10;

    // Decode previous/current filtered {a,b}. A leading B
    // (00 -> 10 -> 11 -> 01 -> 00) counts up, the reverse counts down and
    // a simultaneous change of both bits cannot be attributed to a direction.
    function automatic step_t qei_decode(input logic [1:0] prev_ab,
                                         input logic [1:0] cur_ab);
        step_t s;
        case ({prev_ab, cur_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_UP;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_DOWN;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ERR;
            default:                            s = STEP_NONE;
        endcase
        return s;
    endfunction

    // Signed increment for a step; an illegal transition contributes nothing.
    function automatic logic signed [1:0] step_value(input step_t s);
        logic signed [1:0] v;
        case (s)
            STEP_UP:   v = 2'sb01;
            STEP_DOWN: v = 2'sb11;
            default:   v = 2'sb00;
        endcase
        return v;
    endfunction

    // Report whether a wide signed value lies above, below or inside the
    // two's complement range of a 'width'-bit signed number. The caller
    // substitutes its own width-sized limits, which keeps this reusable
    // for any output width.
    function automatic logic [1:0] sat_check(input logic signed [63:0] val,
                                             input int unsigned        width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic [1:0]         r;
        hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 32'd1));
        if (val > hi) begin
            r = SAT_HI;
        end else if (val < lo) begin
            r = SAT_LO;
        end else begin
            r = SAT_IN;
        end
        return r;
    endfunction

endpackage

// File: rtl/qei_input_filter.sv
// Two-flop synchroniser followed by a stability filter for one encoder pin.
// The filtered bit only follows the synchronised pin once the new level has
// been held for FILTER_LEN consecutive cycles; any bounce restarts the count.
module qei_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic              sync1_reg;
    logic              sync2_reg;
    logic              filt_reg;
    logic [CNT_W-1:0]  cnt_reg;

    // Synchronise the pin, then count how long it has disagreed with the
    // filtered level; accept it when the count reaches FILTER_LEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            filt_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != filt_reg) begin
                if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign filtered = filt_reg;

endmodule

// File: rtl/qei_decoder.sv
// Quadrature encoder front end: filtered A/B/Z pins, 4x decode into a
// wrapping signed position, index capture, sticky illegal-transition flag
// and a windowed, saturated velocity measurement.
module qei_decoder
    import qei_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int POS_W      = 32,
    parameter int VEL_W      = 16,
    parameter int VEL_PERIOD = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_z,
    input  logic                    index_clr_en,
    input  logic                    pos_load,
    input  logic [POS_W-1:0]        pos_load_val,
    input  logic                    err_clr,
    output logic signed [POS_W-1:0] position,
    output logic signed [POS_W-1:0] index_pos,
    output logic                    index_seen,
    output logic                    err,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid
);

    localparam int ACC_W = VEL_W + 2;
    localparam int WIN_W = $clog2(VEL_PERIOD);

    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Pin conditioning: bit 0 = A, bit 1 = B, bit 2 = Z
    // ------------------------------------------------------------------
    logic [2:0] raw_pins;
    logic [2:0] filt;

    assign raw_pins = {enc_z, enc_b, enc_a};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_filter
            qei_input_filter #(
                .FILTER_LEN (FILTER_LEN)
            ) u_filter (
                .clk      (clk),
                .reset    (reset),
                .raw      (raw_pins[gi]),
                .filtered (filt[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode stage
    // ------------------------------------------------------------------
    logic [1:0] cur_ab;
    logic [1:0] prev_ab_reg;
    step_t      step_reg;
    logic       z_prev_reg;
    logic       z_rise_reg;

    assign cur_ab = {filt[0], filt[1]};

    // Register the decoded transition and the index edge so that both
    // reach the position logic in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab_reg <= 2'b00;
            step_reg    <= STEP_NONE;
            z_prev_reg  <= 1'b0;
            z_rise_reg  <= 1'b0;
        end else begin
            prev_ab_reg <= cur_ab;
            step_reg    <= qei_decode(prev_ab_reg, cur_ab);
            z_prev_reg  <= filt[2];
            z_rise_reg  <= filt[2] & ~z_prev_reg;
        end
    end

    logic signed [1:0] step_val;
    assign step_val = step_value(step_reg);

    // ------------------------------------------------------------------
    // Position, index capture and error flag
    // ------------------------------------------------------------------
    logic signed [POS_W-1:0] position_reg;
    logic signed [POS_W-1:0] position_next;
    logic signed [POS_W-1:0] index_pos_reg;
    logic                    index_seen_reg;
    logic                    err_reg;
    logic                    err_next;

    // Load beats index clear, which beats the step; the count wraps.
    always_comb begin
        position_next = position_reg;
        if (pos_load) begin
            position_next = $signed(pos_load_val);
        end else if (z_rise_reg && index_clr_en) begin
            position_next = '0;
        end else begin
            position_next = position_reg + POS_W'(step_val);
        end
    end

    // A new illegal transition wins over a clear issued in the same cycle.
    always_comb begin
        err_next = (err_reg & ~err_clr) | (step_reg == STEP_ERR);
    end

    // Position state; index_pos takes the count from before this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            position_reg   <= '0;
            index_pos_reg  <= '0;
            index_seen_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            position_reg <= position_next;
            err_reg      <= err_next;
            if (z_rise_reg) begin
                index_pos_reg  <= position_reg;
                index_seen_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Velocity window
    // ------------------------------------------------------------------
    logic [WIN_W-1:0]        win_cnt_reg;
    logic                    win_end;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [63:0]      acc_sum;
    logic signed [VEL_W-1:0] vel_sat;
    logic signed [VEL_W-1:0] velocity_reg;
    logic                    vel_valid_reg;

    assign win_end = (win_cnt_reg == WIN_W'(VEL_PERIOD - 1));
    assign acc_sum = 64'(acc_reg) + 64'(step_val);

    // Saturate the running sum both into the accumulator and the output.
    always_comb begin
        case (sat_check(acc_sum, ACC_W))
            SAT_HI:  acc_next = ACC_MAX;
            SAT_LO:  acc_next = ACC_MIN;
            default: acc_next = acc_sum[ACC_W-1:0];
        endcase
        case (sat_check(acc_sum, VEL_W))
            SAT_HI:  vel_sat = VEL_MAX;
            SAT_LO:  vel_sat = VEL_MIN;
            default: vel_sat = acc_sum[VEL_W-1:0];
        endcase
    end

    // Free-running window; the terminal cycle's step is folded into the
    // published value and the accumulator restarts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_reg   <= '0;
            acc_reg       <= '0;
            velocity_reg  <= '0;
            vel_valid_reg <= 1'b0;
        end else begin
            vel_valid_reg <= win_end;
            if (win_end) begin
                win_cnt_reg  <= '0;
                acc_reg      <= '0;
                velocity_reg <= vel_sat;
            end else begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
                acc_reg     <= acc_next;
            end
        end
    end

    assign position   = position_reg;
    assign index_pos  = index_pos_reg;
    assign index_seen = index_seen_reg;
    assign err        = err_reg;
    assign velocity   = velocity_reg;
    assign vel_valid  = vel_valid_reg;

endmodule

// File: tb/tb_qei_decoder.sv
// Directed bench for qei_decoder: gray-code step table, filter glitches,
// illegal transitions, index/load priority, wrap-around and velocity window.
module tb_qei_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enc_a, enc_b, enc_z, enc_a2, enc_b2;
    logic        index_clr_en, pos_load, err_clr;
    logic [31:0] pos_load_val;

    logic signed [31:0] position, index_pos, position2, index_pos2;
    logic               index_seen, err, vel_valid, index_seen2, err2, vel_valid2;
    logic signed [15:0] velocity;
    logic signed [3:0]  velocity2;

    int n_cmp = 0;
    int n_bad = 0;

    qei_decoder #(.FILTER_LEN(4), .POS_W(32), .VEL_W(16), .VEL_PERIOD(100)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .index_clr_en(index_clr_en), .pos_load(pos_load), .pos_load_val(pos_load_val),
        .err_clr(err_clr), .position(position), .index_pos(index_pos),
        .index_seen(index_seen), .err(err), .velocity(velocity), .vel_valid(vel_valid)
    );

    qei_decoder #(.FILTER_LEN(4), .POS_W(32), .VEL_W(4), .VEL_PERIOD(100)) dut_narrow (
        .clk(clk), .reset(reset), .enc_a(enc_a2), .enc_b(enc_b2), .enc_z(enc_z),
        .index_clr_en(index_clr_en), .pos_load(pos_load), .pos_load_val(pos_load_val),
        .err_clr(err_clr), .position(position2), .index_pos(index_pos2),
        .index_seen(index_seen2), .err(err2), .velocity(velocity2), .vel_valid(vel_valid2)
    );

    typedef struct {
        logic a;
        logic b;
        int   exp_pos;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Forward gray sequence {a,b}: 00, 10, 11, 01
    function automatic logic [1:0] gray(input int i);
        logic [1:0] g;
        case (i % 4)
            0: g = 2'b00;
            1: g = 2'b10;
            2: g = 2'b11;
            default: g = 2'b01;
        endcase
        return g;
    endfunction

    initial begin
        int vcount, vcycle, vcount2, vcycle2, prev;

        vecs[0]  = '{1'b1, 1'b0, 1};
        vecs[1]  = '{1'b1, 1'b1, 2};
        vecs[2]  = '{1'b0, 1'b1, 3};
        vecs[3]  = '{1'b0, 1'b0, 4};
        vecs[4]  = '{1'b1, 1'b0, 5};
        vecs[5]  = '{1'b1, 1'b1, 6};
        vecs[6]  = '{1'b0, 1'b1, 7};
        vecs[7]  = '{1'b0, 1'b0, 8};
        vecs[8]  = '{1'b0, 1'b1, 7};
        vecs[9]  = '{1'b1, 1'b1, 6};
        vecs[10] = '{1'b1, 1'b0, 5};

        reset = 1'b1;
        enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0; enc_a2 = 1'b0; enc_b2 = 1'b0;
        index_clr_en = 1'b0; pos_load = 1'b0; err_clr = 1'b0; pos_load_val = '0;
        repeat (3) tick();

        check("reset_position", position, 32'd0);
        check("reset_index_pos", index_pos, 32'd0);
        check("reset_index_seen", 32'(index_seen), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_velocity", velocity, 32'd0);
        check("reset_vel_valid", 32'(vel_valid), 32'd0);

        // Velocity window: 20 steps (12 on the narrow instance) inside the first 100 cycles
        reset = 1'b0;
        {enc_a, enc_b} = gray(1);
        {enc_a2, enc_b2} = gray(1);
        vcount = 0; vcycle = 0; vcount2 = 0; vcycle2 = 0;
        for (int k = 1; k <= 110; k++) begin
            tick();
            if (vel_valid) begin vcount++; vcycle = k; end
            if (vel_valid2) begin vcount2++; vcycle2 = k; end
            if (k % 4 == 0 && k / 4 < 20) begin
                {enc_a, enc_b} = gray(k / 4 + 1);
                if (k / 4 + 1 <= 12) {enc_a2, enc_b2} = gray(k / 4 + 1);
            end
        end
        check("vel_valid_count", vcount, 32'd1);
        check("vel_valid_cycle", vcycle, 32'd100);
        check("velocity_20", velocity, 32'd20);
        check("position_after_20", position, 32'd20);
        check("narrow_vel_valid_cycle", vcycle2, 32'd100);
        check("narrow_vel_valid_count", vcount2, 32'd1);
        check("narrow_velocity_sat", velocity2, 32'd7);
        check("narrow_position_12", position2, 32'd12);

        // Fresh start for the position tests
        reset = 1'b1;
        {enc_a, enc_b} = 2'b00;
        {enc_a2, enc_b2} = 2'b00;
        repeat (3) tick();
        reset = 1'b0;

        // Step table: each transition lands exactly 7 edges after sampling
        prev = 0;
        for (int i = 0; i < 11; i++) begin
            enc_a = vecs[i].a;
            enc_b = vecs[i].b;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (k == 7) check($sformatf("step%0d_before", i), position, prev);
                if (k == 8) begin
                    check($sformatf("step%0d_pos", i), position, vecs[i].exp_pos);
                    check($sformatf("step%0d_err", i), 32'(err), 32'd0);
                end
            end
            prev = vecs[i].exp_pos;
        end

        // Two-cycle glitch on A is rejected
        enc_a = 1'b0;
        repeat (2) tick();
        enc_a = 1'b1;
        repeat (12) tick();
        check("glitch2_pos", position, 32'd5);

        // Four-cycle pulse on A passes: one count down, then back up
        enc_a = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) enc_a = 1'b1;
            if (k == 8) check("glitch4_down", position, 32'd4);
            if (k == 12) check("glitch4_back", position, 32'd5);
        end

        // Illegal 10 -> 01
        enc_a = 1'b0; enc_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) check("illegal_err_early", 32'(err), 32'd0);
            if (k == 8) begin
                check("illegal_err", 32'(err), 32'd1);
                check("illegal_pos", position, 32'd5);
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Illegal 01 -> 10 arriving together with err_clr
        enc_a = 1'b1; enc_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) err_clr = 1'b1;
            tick();
            if (k == 7) check("coincident_err_before", 32'(err), 32'd0);
            if (k == 8) begin
                err_clr = 1'b0;
                check("coincident_err_kept", 32'(err), 32'd1);
                check("coincident_pos", position, 32'd5);
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared2", 32'(err), 32'd0);

        // Load 100, visible next cycle
        pos_load = 1'b1; pos_load_val = 32'd100;
        tick();
        pos_load = 1'b0;
        check("load100", position, 32'd100);
        check("index_seen_before", 32'(index_seen), 32'd0);

        // Index rise with clear enabled and a concurrent step 10 -> 11
        index_clr_en = 1'b1;
        enc_z = 1'b1; enc_a = 1'b1; enc_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) check("index_pos_before", position, 32'd100);
            if (k == 8) begin
                check("index_capture", index_pos, 32'd100);
                check("index_clear_pos", position, 32'd0);
                check("index_seen", 32'(index_seen), 32'd1);
            end
        end
        enc_z = 1'b0;
        repeat (10) tick();
        check("z_fall_pos", position, 32'd0);

        // Index rise, step 11 -> 01, and pos_load 55 all together
        enc_z = 1'b1; enc_a = 1'b0; enc_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) begin pos_load = 1'b1; pos_load_val = 32'd55; end
            tick();
            if (k == 8) begin
                pos_load = 1'b0;
                check("load_over_index_pos", position, 32'd55);
                check("load_over_index_capture", index_pos, 32'd0);
            end
        end
        index_clr_en = 1'b0;

        // Wrap from the largest positive count
        pos_load = 1'b1; pos_load_val = 32'h7FFF_FFFF;
        tick();
        pos_load = 1'b0;
        check("load_max", position, 32'h7FFF_FFFF);
        enc_a = 1'b0; enc_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 8) check("wrap_pos", position, 32'h8000_0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
